// File: rtl/pingpong_buffer_if.sv
// Bus between the ping-pong sequencing controller (master) and the dual-bank
// activation buffer (slave): write/read strobes, addresses, read data and bank status flags.
interface pingpong_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              wr_en1;
  logic              wr_en2;
  logic [ADDR_W-1:0] write_addr1;
  logic [ADDR_W-1:0] write_addr2;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en1;
  logic              rd_en2;
  logic [ADDR_W-1:0] read_addr1;
  logic [ADDR_W-1:0] read_addr2;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full_write1;
  logic              full_write2;
  logic              full_read1;
  logic              full_read2;
  logic              err;

  modport master (
    output wr_en1, wr_en2, write_addr1, write_addr2, wr_data,
    output rd_en1, rd_en2, read_addr1, read_addr2,
    input  rd_data, rd_valid, full_write1, full_write2, full_read1, full_read2, err
  );

  modport slave (
    input  wr_en1, wr_en2, write_addr1, write_addr2, wr_data,
    input  rd_en1, rd_en2, read_addr1, read_addr2,
    output rd_data, rd_valid, full_write1, full_write2, full_read1, full_read2, err
  );
endinterface

// File: rtl/pingpong_buffer.sv
// Dual-bank ping-pong activation buffer with per-bank fill/drain FSMs and status flags.
// Define PPBUF_ERR_EN to gate illegal accesses and raise the sticky err flag.
module pingpong_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input logic              clk,
  input logic              rst,
  pingpong_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } state_e;

  logic [DATA_W-1:0] mem1_q [DEPTH];
  logic [DATA_W-1:0] mem2_q [DEPTH];

  state_e            st1_q, st1_d;
  state_e            st2_q, st2_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              fw1_q, fw2_q;
  logic              fr1_q, fr2_q;
  logic              drain1, drain2;
  logic              wr_acc1, wr_acc2;
  logic              rd_acc1, rd_acc2;

  function automatic logic readable(input state_e s);
    return (s == FULL) || (s == DRAINING);
  endfunction

  // Transitions are keyed on the last address, never on an access count.
  function automatic state_e next_state(input state_e s,
                                        input logic wr, input logic [ADDR_W-1:0] wa,
                                        input logic rd, input logic [ADDR_W-1:0] ra);
    state_e n;
    n = s;
    case (s)
      EMPTY: begin
        if (wr && (wa == LAST))      n = FULL;
        else if (wr)                 n = FILLING;
      end
      FILLING: begin
        if (wr && (wa == LAST))      n = FULL;
      end
      FULL: begin
        if (rd && (ra == LAST))      n = EMPTY;
        else if (rd)                 n = DRAINING;
      end
      default: begin
        if (rd && (ra == LAST))      n = EMPTY;
      end
    endcase
    return n;
  endfunction

`ifdef PPBUF_ERR_EN
  logic can_wr1, can_wr2, can_rd1, can_rd2;
  logic rd2_ok;
  logic illegal;
  logic err_q;

  assign can_wr1 = !readable(st1_q);
  assign can_wr2 = !readable(st2_q);
  assign can_rd1 = readable(st1_q);
  assign can_rd2 = readable(st2_q);

  assign wr_acc1 = bus.wr_en1 && can_wr1;
  assign wr_acc2 = bus.wr_en2 && can_wr2;
  assign rd_acc1 = bus.rd_en1 && can_rd1;
  assign rd2_ok  = bus.rd_en2 && can_rd2;
  // Bank 1 wins a dual read; the dropped bank-2 read counts as illegal.
  assign rd_acc2 = rd2_ok && !rd_acc1;

  assign illegal = (bus.wr_en1 && !can_wr1) || (bus.wr_en2 && !can_wr2) ||
                   (bus.rd_en1 && !can_rd1) || (bus.rd_en2 && !can_rd2) ||
                   (rd2_ok && rd_acc1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 1'b0;
    else if (illegal) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign wr_acc1 = bus.wr_en1;
  assign wr_acc2 = bus.wr_en2;
  assign rd_acc1 = bus.rd_en1;
  assign rd_acc2 = bus.rd_en2 && !bus.rd_en1;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    st1_d     = next_state(st1_q, wr_acc1, bus.write_addr1, rd_acc1, bus.read_addr1);
    st2_d     = next_state(st2_q, wr_acc2, bus.write_addr2, rd_acc2, bus.read_addr2);
    drain1    = readable(st1_q) && rd_acc1 && (bus.read_addr1 == LAST);
    drain2    = readable(st2_q) && rd_acc2 && (bus.read_addr2 == LAST);
    rd_data_d = rd_data_q;
    if (rd_acc1)      rd_data_d = mem1_q[bus.read_addr1];
    else if (rd_acc2) rd_data_d = mem2_q[bus.read_addr2];
  end

  // ---- storage write: lands on the sampling edge ----
  always_ff @(posedge clk) begin
    if (wr_acc1) mem1_q[bus.write_addr1] <= bus.wr_data;
    if (wr_acc2) mem2_q[bus.write_addr2] <= bus.wr_data;
  end

  // ---- FSM and registered outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st1_q      <= EMPTY;
      st2_q      <= EMPTY;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      fw1_q      <= 1'b0;
      fw2_q      <= 1'b0;
      fr1_q      <= 1'b0;
      fr2_q      <= 1'b0;
    end else begin
      st1_q      <= st1_d;
      st2_q      <= st2_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_acc1 || rd_acc2;
      fw1_q      <= readable(st1_d);
      fw2_q      <= readable(st2_d);
      fr1_q      <= drain1;
      fr2_q      <= drain2;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.full_write1 = fw1_q;
  assign bus.full_write2 = fw2_q;
  assign bus.full_read1  = fr1_q;
  assign bus.full_read2  = fr2_q;
endmodule
